// File: rtl/vga_pkg.sv
// Shared VGA timing constants and helpers used by the raster generator and its axis counters.
package vga_pkg;

    localparam int unsigned VGA640_H_ACTIVE = 640;
    localparam int unsigned VGA640_H_FP     = 16;
    localparam int unsigned VGA640_H_SYNC   = 96;
    localparam int unsigned VGA640_H_BP     = 48;
    localparam int unsigned VGA640_V_ACTIVE = 480;
    localparam int unsigned VGA640_V_FP     = 10;
    localparam int unsigned VGA640_V_SYNC   = 2;
    localparam int unsigned VGA640_V_BP     = 33;
    localparam bit          VGA640_HS_POL   = 1'b0;
    localparam bit          VGA640_VS_POL   = 1'b0;

    // 800x600@60 uses positive sync on both axes.
    localparam int unsigned VGA800_H_ACTIVE = 800;
    localparam int unsigned VGA800_H_FP     = 40;
    localparam int unsigned VGA800_H_SYNC   = 128;
    localparam int unsigned VGA800_H_BP     = 88;
    localparam int unsigned VGA800_V_ACTIVE = 600;
    localparam int unsigned VGA800_V_FP     = 1;
    localparam int unsigned VGA800_V_SYNC   = 4;
    localparam int unsigned VGA800_V_BP     = 23;
    localparam bit          VGA800_HS_POL   = 1'b1;
    localparam bit          VGA800_VS_POL   = 1'b1;

    function automatic int unsigned vga_total(input int unsigned active,
                                              input int unsigned fp,
                                              input int unsigned sync,
                                              input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_axis_cnt.sv
// One raster axis: a position counter with combinational active/sync/wrap decode of the
// position it is about to emit.
module vga_axis_cnt
    import vga_pkg::*;
#(
    parameter int unsigned ACTIVE = 640,
    parameter int unsigned FP     = 16,
    parameter int unsigned SYNC   = 96,
    parameter int unsigned BP     = 48,
    parameter bit          POL    = 1'b0,
    parameter int unsigned CNT_W  = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             adv,
    output logic [CNT_W-1:0] cnt,
    output logic             active,
    output logic             sync,
    output logic             wrap
);

    localparam int unsigned      TOTAL      = vga_total(ACTIVE, FP, SYNC, BP);
    localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] ACTIVE_END = CNT_W'(ACTIVE);
    localparam logic [CNT_W-1:0] SYNC_START = CNT_W'(ACTIVE + FP);
    localparam logic [CNT_W-1:0] SYNC_END   = CNT_W'(ACTIVE + FP + SYNC);

    if (ACTIVE == 0 || FP == 0 || SYNC == 0 || BP == 0) begin : g_bad_phase
        $error("vga_axis_cnt: every timing phase must be at least one unit wide");
    end
    if (64'(TOTAL) > (64'd1 << CNT_W)) begin : g_bad_width
        $error("vga_axis_cnt: CNT_W too narrow for the axis total");
    end

    logic [CNT_W-1:0] r_cnt;
    logic             w_last;

    assign w_last = (r_cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (adv) begin
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

    // Phase order along the axis is active, front porch, sync, back porch.
    assign cnt    = r_cnt;
    assign active = (r_cnt < ACTIVE_END);
    assign sync   = ((r_cnt >= SYNC_START) && (r_cnt < SYNC_END)) ? POL : ~POL;
    assign wrap   = w_last;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: registered sync/draw/position outputs,
// start-of-line/frame strobes and a completed-frame counter, paced by a pixel enable.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = VGA640_H_ACTIVE,
    parameter int unsigned H_FP     = VGA640_H_FP,
    parameter int unsigned H_SYNC   = VGA640_H_SYNC,
    parameter int unsigned H_BP     = VGA640_H_BP,
    parameter int unsigned V_ACTIVE = VGA640_V_ACTIVE,
    parameter int unsigned V_FP     = VGA640_V_FP,
    parameter int unsigned V_SYNC   = VGA640_V_SYNC,
    parameter int unsigned V_BP     = VGA640_V_BP,
    parameter bit          HS_POL   = VGA640_HS_POL,
    parameter bit          VS_POL   = VGA640_VS_POL,
    parameter int unsigned CNT_W    = 10,
    parameter int unsigned FRAME_W  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ce,
    output logic               draw,
    output logic               hs,
    output logic               vs,
    output logic [CNT_W-1:0]   x,
    output logic [CNT_W-1:0]   y,
    output logic               sol,
    output logic               sof,
    output logic [FRAME_W-1:0] frame_cnt
);

    if (FRAME_W == 0) begin : g_bad_frame_w
        $error("vga_timing_gen: FRAME_W must be at least 1");
    end

    logic [CNT_W-1:0]   w_hc;
    logic [CNT_W-1:0]   w_vc;
    logic               w_h_active;
    logic               w_v_active;
    logic               w_h_sync;
    logic               w_v_sync;
    logic               w_h_wrap;
    logic               w_v_wrap;
    logic               w_v_adv;

    logic [FRAME_W-1:0] r_frame;
    logic [CNT_W-1:0]   r_x;
    logic [CNT_W-1:0]   r_y;
    logic               r_draw;
    logic               r_hs;
    logic               r_vs;
    logic               r_sol;
    logic               r_sof;
    logic [FRAME_W-1:0] r_frame_cnt;

    assign w_v_adv = ce & w_h_wrap;

    vga_axis_cnt #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .POL    (HS_POL),
        .CNT_W  (CNT_W)
    ) u_h_axis (
        .clk    (clk),
        .rst_n  (rst_n),
        .adv    (ce),
        .cnt    (w_hc),
        .active (w_h_active),
        .sync   (w_h_sync),
        .wrap   (w_h_wrap)
    );

    vga_axis_cnt #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .POL    (VS_POL),
        .CNT_W  (CNT_W)
    ) u_v_axis (
        .clk    (clk),
        .rst_n  (rst_n),
        .adv    (w_v_adv),
        .cnt    (w_vc),
        .active (w_v_active),
        .sync   (w_v_sync),
        .wrap   (w_v_wrap)
    );

    // Bumps alongside the raster wrap so the registered copy below lands together with sof.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame <= '0;
        end else if (ce && w_h_wrap && w_v_wrap) begin
            r_frame <= r_frame + 1'b1;
        end
    end

    // All outputs sample the same pre-increment position; strobes drop on any non-ce edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x         <= '0;
            r_y         <= '0;
            r_draw      <= 1'b0;
            r_hs        <= ~HS_POL;
            r_vs        <= ~VS_POL;
            r_sol       <= 1'b0;
            r_sof       <= 1'b0;
            r_frame_cnt <= '0;
        end else if (ce) begin
            r_x         <= w_hc;
            r_y         <= w_vc;
            r_draw      <= w_h_active & w_v_active;
            r_hs        <= w_h_sync;
            r_vs        <= w_v_sync;
            r_sol       <= (w_hc == '0);
            r_sof       <= (w_hc == '0) && (w_vc == '0);
            r_frame_cnt <= r_frame;
        end else begin
            r_sol       <= 1'b0;
            r_sof       <= 1'b0;
        end
    end

    assign x         = r_x;
    assign y         = r_y;
    assign draw      = r_draw;
    assign hs        = r_hs;
    assign vs        = r_vs;
    assign sol       = r_sol;
    assign sof       = r_sof;
    assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: a default 640x480 instance and a tiny 8x6 raster,
// each checked against its own reference model through a scoreboard queue.
module tb_vga_timing_gen;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       draw;
        logic       hs;
        logic       vs;
        logic       sol;
        logic       sof;
        logic [7:0] frame;
    } exp_t;

    localparam exp_t RST_A = '{x: 10'd0, y: 10'd0, draw: 1'b0, hs: 1'b1, vs: 1'b1,
                               sol: 1'b0, sof: 1'b0, frame: 8'd0};
    localparam exp_t RST_B = '{x: 10'd0, y: 10'd0, draw: 1'b0, hs: 1'b0, vs: 1'b0,
                               sol: 1'b0, sof: 1'b0, frame: 8'd0};

    logic       clk = 1'b0;
    logic       rstA_n;
    logic       ceA;
    logic       rstB_n;
    logic       ceB;

    logic       drawA, hsA, vsA, solA, sofA;
    logic [9:0] xA, yA;
    logic [7:0] frameA;
    logic       drawB, hsB, vsB, solB, sofB;
    logic [3:0] xB, yB;
    logic [1:0] frameB;

    int         checks = 0;
    int         errors = 0;

    exp_t       qA[$];
    exp_t       qB[$];
    exp_t       lastA;
    exp_t       lastB;
    int         mhA, mvA, mhB, mvB;
    logic [7:0] mfA;
    logic [1:0] mfB;

    vga_timing_gen dutA (
        .clk       (clk),
        .rst_n     (rstA_n),
        .ce        (ceA),
        .draw      (drawA),
        .hs        (hsA),
        .vs        (vsA),
        .x         (xA),
        .y         (yA),
        .sol       (solA),
        .sof       (sofA),
        .frame_cnt (frameA)
    );

    vga_timing_gen #(
        .H_ACTIVE (4), .H_FP (1), .H_SYNC (2), .H_BP (1),
        .V_ACTIVE (3), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .HS_POL   (1'b1), .VS_POL (1'b1),
        .CNT_W    (4), .FRAME_W (2)
    ) dutB (
        .clk       (clk),
        .rst_n     (rstB_n),
        .ce        (ceB),
        .draw      (drawB),
        .hs        (hsB),
        .vs        (vsB),
        .x         (xB),
        .y         (yB),
        .sol       (solB),
        .sof       (sofB),
        .frame_cnt (frameB)
    );

    always #5 clk = ~clk;

    function automatic exp_t obsA();
        exp_t o;
        o = '{x: xA, y: yA, draw: drawA, hs: hsA, vs: vsA, sol: solA, sof: sofA, frame: frameA};
        return o;
    endfunction

    function automatic exp_t obsB();
        exp_t o;
        o = '{x: {6'd0, xB}, y: {6'd0, yB}, draw: drawB, hs: hsB, vs: vsB,
              sol: solB, sof: sofB, frame: {6'd0, frameB}};
        return o;
    endfunction

    // Default 800x525 raster: predict this pixel, advance the model, then clock it through.
    task automatic stepA(input logic c);
        exp_t e;
        ceA = c;
        if (c) begin
            e.x     = 10'(mhA);
            e.y     = 10'(mvA);
            e.draw  = (mhA < 640) && (mvA < 480);
            e.hs    = !((mhA >= 656) && (mhA <= 751));
            e.vs    = !((mvA >= 490) && (mvA <= 491));
            e.sol   = (mhA == 0);
            e.sof   = (mhA == 0) && (mvA == 0);
            e.frame = mfA;
            if (mhA == 799) begin
                mhA = 0;
                if (mvA == 524) begin
                    mvA = 0;
                    mfA++;
                end else begin
                    mvA++;
                end
            end else begin
                mhA++;
            end
        end else begin
            e     = lastA;
            e.sol = 1'b0;
            e.sof = 1'b0;
        end
        lastA = e;
        qA.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Tiny 8x6 raster, positive syncs, 2-bit frame counter.
    task automatic stepB(input logic c);
        exp_t e;
        ceB = c;
        if (c) begin
            e.x     = 10'(mhB);
            e.y     = 10'(mvB);
            e.draw  = (mhB < 4) && (mvB < 3);
            e.hs    = (mhB == 5) || (mhB == 6);
            e.vs    = (mvB == 4);
            e.sol   = (mhB == 0);
            e.sof   = (mhB == 0) && (mvB == 0);
            e.frame = {6'd0, mfB};
            if (mhB == 7) begin
                mhB = 0;
                if (mvB == 5) begin
                    mvB = 0;
                    mfB++;
                end else begin
                    mvB++;
                end
            end else begin
                mhB++;
            end
        end else begin
            e     = lastB;
            e.sol = 1'b0;
            e.sof = 1'b0;
        end
        lastB = e;
        qB.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic modelResetA();
        mhA = 0; mvA = 0; mfA = 8'd0; lastA = RST_A; qA.delete();
    endtask

    task automatic modelResetB();
        mhB = 0; mvB = 0; mfB = 2'd0; lastB = RST_B; qB.delete();
    endtask

    task automatic resetA();
        ceA = 1'b0;
        rstA_n = 1'b0;
        @(posedge clk);
        #1;
        rstA_n = 1'b1;
        modelResetA();
    endtask

    task automatic resetB();
        ceB = 1'b0;
        rstB_n = 1'b0;
        @(posedge clk);
        #1;
        rstB_n = 1'b1;
        modelResetB();
    endtask

    task automatic test_reset();
        exp_t o, e;
        rstA_n = 1'b0; rstB_n = 1'b0; ceA = 1'b1; ceB = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        o = obsA();
        checks++;
        if (o !== RST_A) begin
            errors++;
            $display("[TB] FAIL reset_A: got %h exp %h", o, RST_A);
        end
        o = obsB();
        checks++;
        if (o !== RST_B) begin
            errors++;
            $display("[TB] FAIL reset_B: got %h exp %h", o, RST_B);
        end
        rstA_n = 1'b1;
        modelResetA();
        stepA(1'b1);
        o = obsA();
        e = qA.pop_front();
        checks++;
        if (o !== e) begin
            errors++;
            $display("[TB] FAIL first_pixel: got %h exp %h", o, e);
        end
        checks++;
        if ({drawA, solA, sofA, xA, yA} !== {3'b111, 20'd0}) begin
            errors++;
            $display("[TB] FAIL first_pixel_strobes: got draw=%b sol=%b sof=%b x=%0d y=%0d exp 1 1 1 0 0",
                     drawA, solA, sofA, xA, yA);
        end
    endtask

    task automatic test_default_run();
        exp_t o, e;
        int hsCnt = 0, hsMin = 1023, hsMax = 0, drawCnt = 0, lastSol = -1, solCnt = 0;
        resetA();
        for (int i = 0; i < 1700; i++) begin
            stepA(1'b1);
            o = obsA();
            e = qA.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("[TB] FAIL default_pixel: step %0d got %h exp %h", i, o, e);
            end
            if (yA == 10'd0 && hsA == 1'b0) begin
                hsCnt++;
                if (int'(xA) < hsMin) hsMin = int'(xA);
                if (int'(xA) > hsMax) hsMax = int'(xA);
            end
            if (yA == 10'd0 && drawA) drawCnt++;
            if (solA) begin
                if (lastSol >= 0) begin
                    checks++;
                    if (i - lastSol !== 800) begin
                        errors++;
                        $display("[TB] FAIL sol_period: got %0d exp 800", i - lastSol);
                    end
                end
                lastSol = i;
                solCnt++;
            end
        end
        checks++;
        if (hsCnt !== 96) begin
            errors++;
            $display("[TB] FAIL hs_width: got %0d exp 96", hsCnt);
        end
        checks++;
        if (hsMin !== 656 || hsMax !== 751) begin
            errors++;
            $display("[TB] FAIL hs_range: got %0d..%0d exp 656..751", hsMin, hsMax);
        end
        checks++;
        if (drawCnt !== 640) begin
            errors++;
            $display("[TB] FAIL draw_width: got %0d exp 640", drawCnt);
        end
        checks++;
        if (solCnt !== 3) begin
            errors++;
            $display("[TB] FAIL sol_count: got %0d exp 3", solCnt);
        end
    endtask

    task automatic test_ce_toggle();
        exp_t o, e;
        int lastSol = -1, solCnt = 0;
        resetA();
        for (int i = 0; i < 3400; i++) begin
            stepA((i % 2) == 0);
            o = obsA();
            e = qA.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("[TB] FAIL ce_toggle_pixel: step %0d got %h exp %h", i, o, e);
            end
            if (solA) begin
                if (lastSol >= 0) begin
                    checks++;
                    if (i - lastSol !== 1600) begin
                        errors++;
                        $display("[TB] FAIL ce_sol_period: got %0d exp 1600", i - lastSol);
                    end
                end
                lastSol = i;
                solCnt++;
            end
        end
        checks++;
        if (solCnt !== 3) begin
            errors++;
            $display("[TB] FAIL ce_sol_count: got %0d exp 3", solCnt);
        end
    endtask

    task automatic test_reset_mid();
        exp_t o, e;
        resetA();
        for (int i = 0; i < 1101; i++) begin
            stepA(1'b1);
            o = obsA();
            e = qA.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("[TB] FAIL mid_run_pixel: step %0d got %h exp %h", i, o, e);
            end
        end
        checks++;
        if (xA !== 10'd300 || yA !== 10'd1) begin
            errors++;
            $display("[TB] FAIL mid_position: got x=%0d y=%0d exp x=300 y=1", xA, yA);
        end
        #1;
        rstA_n = 1'b0;
        #1;
        o = obsA();
        checks++;
        if (o !== RST_A) begin
            errors++;
            $display("[TB] FAIL async_reset: got %h exp %h", o, RST_A);
        end
        @(posedge clk);
        #1;
        rstA_n = 1'b1;
        modelResetA();
        stepA(1'b1);
        o = obsA();
        e = qA.pop_front();
        checks++;
        if (o !== e) begin
            errors++;
            $display("[TB] FAIL restart_pixel: got %h exp %h", o, e);
        end
    endtask

    task automatic test_tiny();
        exp_t o, e;
        logic [1:0] seen[6];
        logic [1:0] expFrames[6];
        int lastSof = -1, nSof = 0;
        expFrames = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        resetB();
        for (int i = 0; i < 260; i++) begin
            stepB(1'b1);
            o = obsB();
            e = qB.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("[TB] FAIL tiny_pixel: step %0d got %h exp %h", i, o, e);
            end
            if (sofB) begin
                if (nSof < 6) seen[nSof] = frameB;
                if (lastSof >= 0) begin
                    checks++;
                    if (i - lastSof !== 48) begin
                        errors++;
                        $display("[TB] FAIL tiny_frame_period: got %0d exp 48", i - lastSof);
                    end
                end
                lastSof = i;
                nSof++;
            end
        end
        checks++;
        if (nSof !== 6) begin
            errors++;
            $display("[TB] FAIL tiny_sof_count: got %0d exp 6", nSof);
        end else begin
            for (int k = 0; k < 6; k++) begin
                checks++;
                if (seen[k] !== expFrames[k]) begin
                    errors++;
                    $display("[TB] FAIL tiny_frame_cnt: sof %0d got %0d exp %0d", k, seen[k], expFrames[k]);
                end
            end
        end
        checks++;
        if (frameB !== 2'd1) begin
            errors++;
            $display("[TB] FAIL tiny_frame_before_reset: got %0d exp 1", frameB);
        end
        #1;
        rstB_n = 1'b0;
        #1;
        o = obsB();
        checks++;
        if (o !== RST_B) begin
            errors++;
            $display("[TB] FAIL tiny_async_reset: got %h exp %h", o, RST_B);
        end
        @(posedge clk);
        #1;
        rstB_n = 1'b1;
        modelResetB();
        stepB(1'b1);
        o = obsB();
        e = qB.pop_front();
        checks++;
        if (o !== e) begin
            errors++;
            $display("[TB] FAIL tiny_restart_pixel: got %h exp %h", o, e);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rstA_n = 1'b0;
        rstB_n = 1'b0;
        ceA    = 1'b0;
        ceB    = 1'b0;
        modelResetA();
        modelResetB();
        test_reset();
        test_default_run();
        test_ce_toggle();
        test_reset_mid();
        test_tiny();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
